encoder_8to3: RTL and testbench

ENCODER_8TO3 -- requirements
Module: encoder_8to3

---
 rtl/encoder_pkg.sv | 14 +
 rtl/encoder_8to3_if.sv | 33 +++
 rtl/prio_sel_8.sv | 28 ++
 rtl/encoder_8to3.sv | 101 ++++++++++
 tb/tb_encoder_8to3.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// Shared constants and types for the 8-to-3 request encoder.
// Lines are numbered 0..7; a code is the 3-bit index of one line.
package encoder_pkg;

   localparam int N_LINES = 8;
   localparam int CODE_W  = 3;

   typedef logic [CODE_W-1:0] code_t;

   function automatic logic [N_LINES-1:0] code_to_onehot(input code_t c);
      return {{(N_LINES-1){1'b0}}, 1'b1} << c;
   endfunction

endpackage

// File: rtl/encoder_8to3_if.sv
// Request/code bus of encoder_8to3: request lines in, code with valid/ready out.
// master = encoder side, slave = the environment driving requests and consuming codes.
interface encoder_8to3_if #(
   parameter int DROP_W = 8
);
   import encoder_pkg::*;

   logic [N_LINES-1:0] req_in;
   code_t              code_out;
   logic               valid_out;
   logic               ready_in;
   logic [N_LINES-1:0] pending_out;
   logic [DROP_W-1:0]  drop_cnt;

   modport master (
      input  req_in,
      input  ready_in,
      output code_out,
      output valid_out,
      output pending_out,
      output drop_cnt
   );

   modport slave (
      output req_in,
      output ready_in,
      input  code_out,
      input  valid_out,
      input  pending_out,
      input  drop_cnt
   );

endinterface

// File: rtl/prio_sel_8.sv
// Circular priority search: returns the first set bit of vec found when
// scanning upward from index start and wrapping past bit 7.
module prio_sel_8
   import encoder_pkg::*;
(
   input  logic [N_LINES-1:0] vec,
   input  code_t              start,
   output code_t              code,
   output logic               found
);

   code_t idx;

   // Scan from the far end back toward start so the nearest hit is written last.
   always_comb begin
      code  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = N_LINES - 1; i >= 0; i--) begin
         idx = start + code_t'(i);
         if (vec[idx]) begin
            code  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_8to3.sv
// Captures 8 request lines into a pending register and issues one 3-bit code per
// valid/ready transfer. Define ENCODER_RR_PRIO_EN for round-robin selection.
module encoder_8to3
   import encoder_pkg::*;
#(
   parameter int DROP_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   encoder_8to3_if.master bus
);

   localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

   function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] acc,
                                                 input logic [3:0]        inc);
      int unsigned sum;
      sum = int'(acc) + int'(inc);
      if (sum > DROP_MAX) sum = DROP_MAX;
      return DROP_W'(sum);
   endfunction

   logic               run_p0;
   logic [N_LINES-1:0] pend_p0;
   code_t              code_p1;
   logic               vld_p1;
   logic [DROP_W-1:0]  drop_cnt_q;

   logic [N_LINES-1:0] sel_vec;
   code_t              sel_start;
   code_t              sel_code;
   logic               sel_found;
   code_t              pick;
   logic               xfer;
   logic               load;
   logic [N_LINES-1:0] load_mask;
   logic [N_LINES-1:0] drop_vec;
   logic [3:0]         drop_inc;

   // Release is seen one edge after rst_n rises, so req_in is first sampled on the second edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_p0 <= 1'b0;
      else        run_p0 <= 1'b1;
   end

   prio_sel_8 u_prio_sel (
      .vec   (sel_vec),
      .start (sel_start),
      .code  (sel_code),
      .found (sel_found)
   );

`ifdef ENCODER_RR_PRIO_EN
   code_t rr_ptr_q;

   assign sel_vec   = pend_p0;
   assign sel_start = rr_ptr_q;
   assign pick      = sel_code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                rr_ptr_q <= '0;
      else if (run_p0 && load)   rr_ptr_q <= pick + code_t'(1);
   end
`else
   // Upward search on the mirrored vector finds the highest set line; mirror the index back.
   assign sel_vec   = {<<{pend_p0}};
   assign sel_start = '0;
   assign pick      = ~sel_code;
`endif

   assign xfer      = vld_p1 & bus.ready_in;
   assign load      = sel_found & (~vld_p1 | xfer);
   assign load_mask = load ? code_to_onehot(pick) : '0;
   assign drop_vec  = bus.req_in & pend_p0 & ~load_mask;
   assign drop_inc  = 4'($countones(drop_vec));

   // Stage p0: pending capture; stage p1: issued code and drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_p0    <= '0;
         code_p1    <= '0;
         vld_p1     <= 1'b0;
         drop_cnt_q <= '0;
      end else if (run_p0) begin
         pend_p0    <= (pend_p0 & ~load_mask) | bus.req_in;
         if (load)
            code_p1 <= pick;
         if (load)
            vld_p1  <= 1'b1;
         else if (xfer)
            vld_p1  <= 1'b0;
         drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
      end
   end

   assign bus.code_out    = code_p1;
   assign bus.valid_out   = vld_p1;
   assign bus.pending_out = pend_p0;
   assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed bench for encoder_8to3: codes are checked through a scoreboard on every
// transfer, plus direct checks of reset, latency, hold, drop counting and saturation.
module tb_encoder_8to3;
   import encoder_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   encoder_8to3_if #(.DROP_W(8)) bus  ();
   encoder_8to3_if #(.DROP_W(2)) bus2 ();

   encoder_8to3 #(.DROP_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   encoder_8to3 #(.DROP_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   int    n_assert = 0;
   int    n_fail   = 0;
   code_t sb[$];

   code_t a5_exp    [4];
   code_t drain_exp [4];
   logic [7:0] rst_req;
   code_t      rst_code;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every transfer seen before an edge must match the oldest expected code.
   always @(negedge clk) begin
      code_t e;
      if (rst_n === 1'b1 && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
         e = 'x;
         if (sb.size() > 0) e = sb.pop_front();
         chk("xfer_code", 32'(bus.code_out), 32'(e));
      end
   end

   initial begin
`ifdef ENCODER_RR_PRIO_EN
      a5_exp    = '{3'd0, 3'd2, 3'd5, 3'd7};
      drain_exp = '{3'd1, 3'd2, 3'd3, 3'd0};
      rst_req   = 8'h0E;
      rst_code  = 3'd1;
`else
      a5_exp    = '{3'd7, 3'd5, 3'd2, 3'd0};
      drain_exp = '{3'd3, 3'd2, 3'd1, 3'd0};
      rst_req   = 8'h1C;
      rst_code  = 3'd4;
`endif
      rst_n         = 1'b0;
      bus.req_in    = '0;
      bus.ready_in  = 1'b0;
      bus2.req_in   = '0;
      bus2.ready_in = 1'b0;
      tick();
      tick();
      chk("rst_code",    32'(bus.code_out),    0);
      chk("rst_valid",   32'(bus.valid_out),   0);
      chk("rst_pending", 32'(bus.pending_out), 0);
      chk("rst_drop",    32'(bus.drop_cnt),    0);

      // Release reset with A5 already present: edge 1 ignores it, edge 2 captures it.
      rst_n        = 1'b1;
      bus.req_in   = 8'hA5;
      bus.ready_in = 1'b1;
      for (int i = 0; i < 4; i++) sb.push_back(a5_exp[i]);
      tick();
      chk("sync_edge1_pending", 32'(bus.pending_out), 0);
      tick();
      chk("sync_edge2_pending", 32'(bus.pending_out), 32'h A5);
      chk("sync_edge2_valid",   32'(bus.valid_out),   0);
      bus.req_in = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("a5_valid", 32'(bus.valid_out), 1);
         chk("a5_code",  32'(bus.code_out),  32'(a5_exp[i]));
      end
      tick();
      chk("a5_valid_end",   32'(bus.valid_out),   0);
      chk("a5_pending_end", 32'(bus.pending_out), 0);
      chk("a5_drop",        32'(bus.drop_cnt),    0);

      // Single request on an idle block: code appears on the second edge.
      bus.req_in = 8'h10;
      sb.push_back(3'd4);
      tick();
      chk("lat_edge1_valid", 32'(bus.valid_out), 0);
      bus.req_in = '0;
      tick();
      chk("lat_valid",   32'(bus.valid_out),   1);
      chk("lat_code",    32'(bus.code_out),    4);
      chk("lat_pending", 32'(bus.pending_out), 0);
      tick();
      chk("lat_valid_end", 32'(bus.valid_out), 0);

      // Consumer stalled, line 0 requested for 4 edges: 1 loaded, 1 pending, 2 dropped.
      bus.ready_in = 1'b0;
      bus.req_in   = 8'h01;
      sb.push_back(3'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", 32'(bus.valid_out), 1);
         chk("hold_code",  32'(bus.code_out),  0);
      end
      chk("hold_drop",    32'(bus.drop_cnt),    2);
      chk("hold_pending", 32'(bus.pending_out), 32'h01);

      // Multi-bit requests while stalled: only already-pending lines count as drops.
      bus.req_in = 8'h0F;
      tick();
      chk("multi_drop1", 32'(bus.drop_cnt), 3);
      tick();
      chk("multi_drop2",   32'(bus.drop_cnt),    7);
      chk("multi_pending", 32'(bus.pending_out), 32'h0F);
      bus.req_in   = '0;
      bus.ready_in = 1'b1;
      for (int i = 0; i < 4; i++) sb.push_back(drain_exp[i]);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("drain_code", 32'(bus.code_out), 32'(drain_exp[i]));
         tick();
      end
      chk("drain_valid_end",   32'(bus.valid_out),   0);
      chk("drain_pending_end", 32'(bus.pending_out), 0);

      // Narrow counter: 7 drops with DROP_W=2 saturates at 3.
      bus2.req_in = 8'h01;
      for (int i = 0; i < 4; i++) tick();
      chk("sat_drop_mid", 32'(bus2.drop_cnt), 2);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_drop_end", 32'(bus2.drop_cnt), 3);
      chk("sat_valid",    32'(bus2.valid_out), 1);
      bus2.req_in = '0;

      // Reset while a code is held and 0C is pending: nothing may issue afterwards.
      bus.ready_in = 1'b0;
      bus.req_in   = rst_req;
      tick();
      bus.req_in = '0;
      tick();
      chk("pre_rst_valid",   32'(bus.valid_out),   1);
      chk("pre_rst_code",    32'(bus.code_out),    32'(rst_code));
      chk("pre_rst_pending", 32'(bus.pending_out), 32'h0C);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_code",     32'(bus.code_out),    0);
      chk("arst_valid",    32'(bus.valid_out),   0);
      chk("arst_pending",  32'(bus.pending_out), 0);
      chk("arst_drop",     32'(bus.drop_cnt),    0);
      chk("arst_sat_drop", 32'(bus2.drop_cnt),   0);
      tick();
      rst_n        = 1'b1;
      bus.ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_valid", 32'(bus.valid_out), 0);
      end
      chk("post_rst_pending", 32'(bus.pending_out), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
